// File: rtl/stage3_writeback.sv
// Memory/writeback stage of the 3-stage RV32I pipeline: holds the instruction leaving
// execute, runs its load/store over a valid/ready data port and drives the register-file write.
module stage3_writeback #(
  parameter logic [31:0] NOP_INST      = 32'h00000013,
  parameter int unsigned TIMEOUT_CYCLS = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] stage2_inst_in,
  input  logic [31:0] stage2_pc_in,
  input  logic [31:0] stage2_alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic        stage2_valid,
  output logic [31:0] stage3_inst,
  output logic [31:0] wb_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        stall_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_err
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_RSP = 1'b1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLS);

  logic [31:0] s3_inst_q;
  logic [31:0] s3_pc_q;
  logic [31:0] s3_alu_q;
  logic [31:0] s3_rs2_q;
  logic [0:0]  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        err_q, err_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  offset;
  logic        is_load;
  logic        is_store;
  logic        is_jump;
  logic        mem_op;
  logic        writes_rd;
  logic        req_fire;
  logic        rsp_hit;
  logic        timeout_hit;
  logic        complete;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [3:0]  store_mask;
  logic [31:0] store_data;

  assign opcode   = s3_inst_q[6:0];
  assign rd       = s3_inst_q[11:7];
  assign funct3   = s3_inst_q[14:12];
  assign offset   = s3_alu_q[1:0];

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_jump  = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign mem_op   = is_load || is_store;

  always_comb begin
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_LOAD: writes_rd = 1'b1;
      default:                     writes_rd = 1'b0;
    endcase
  end

  assign dmem_req_valid = (state_q == IDLE) && mem_op;
  assign req_fire       = dmem_req_valid && dmem_req_ready;
  assign rsp_hit        = (state_q == WAIT_RSP) && dmem_rsp_valid;
  assign timeout_hit    = (state_q == WAIT_RSP) && !dmem_rsp_valid && (count_q == TIMEOUT_CNT);

  // A stage-3 instruction retires in the cycle "complete" is high; anything else stalls.
  always_comb begin
    complete = 1'b1;
    if (state_q == WAIT_RSP) begin
      complete = rsp_hit || timeout_hit;
    end else if (mem_op) begin
      complete = is_store && dmem_req_ready;
    end
  end

  assign stall_out = !complete;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      count_d = 8'd0;
      if (is_load && req_fire) begin
        state_d = WAIT_RSP;
      end
    end else begin
      if (rsp_hit) begin
        state_d = IDLE;
        count_d = 8'd0;
      end else if (timeout_hit) begin
        state_d = IDLE;
        count_d = 8'd0;
        err_d   = 1'b1;
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Freezing this register while stalled also keeps the request fields stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_inst_q <= NOP_INST;
      s3_pc_q   <= 32'd0;
      s3_alu_q  <= 32'd0;
      s3_rs2_q  <= 32'd0;
    end else if (!stall_out) begin
      s3_inst_q <= stage2_valid ? stage2_inst_in : NOP_INST;
      s3_pc_q   <= stage2_pc_in;
      s3_alu_q  <= stage2_alu_in;
      s3_rs2_q  <= rs2_data_in;
    end
  end

  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (offset)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    store_mask = 4'b0000;
    store_data = 32'd0;
    if (is_store) begin
      case (funct3)
        3'b000: begin
          store_mask = 4'b0001 << offset;
          store_data = s3_rs2_q << {offset, 3'b000};
        end
        3'b001: begin
          store_mask = 4'b0011 << {offset[1], 1'b0};
          store_data = s3_rs2_q << {offset[1], 4'b0000};
        end
        default: begin
          store_mask = 4'b1111;
          store_data = s3_rs2_q;
        end
      endcase
    end
  end

  // A timed-out load writes zero, since no response data ever arrived.
  always_comb begin
    if (is_jump) begin
      wb_data = s3_pc_q + 32'd4;
    end else if (is_load) begin
      wb_data = rsp_hit ? load_data : 32'd0;
    end else begin
      wb_data = s3_alu_q;
    end
  end

  assign rf_we       = complete && writes_rd && (rd != 5'd0);
  assign rf_waddr    = rd;
  assign stage3_inst = s3_inst_q;
  assign dmem_addr   = {s3_alu_q[31:2], 2'b00};
  assign dmem_we     = store_mask;
  assign dmem_wdata  = store_data;
  assign dmem_err    = err_q;

endmodule

// File: tb/tb_stage3_writeback.sv
// Bench for stage3_writeback: random instruction stream with a responsive memory model,
// scoreboarded against a reference model built from RV32I load/store semantics.
module tb_stage3_writeback;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic        valid;
    int          readyDelay;
    int          rspDelay;
    bit          noRsp;
  } item_t;

  typedef struct {
    logic [31:0] inst;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wb;
    bit          mem;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          stall;
    bit          timeout;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] stage2_inst_in;
  logic [31:0] stage2_pc_in;
  logic [31:0] stage2_alu_in;
  logic [31:0] rs2_data_in;
  logic        stage2_valid;
  logic [31:0] stage3_inst;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        stall_out;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;

  int    checks = 0;
  int    failures = 0;
  bit    monOn = 0;
  bit    memAuto = 1;
  bit    draining = 0;
  exp_t  sbq[$];
  item_t mq[$];

  stage3_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .stage2_inst_in(stage2_inst_in), .stage2_pc_in(stage2_pc_in),
    .stage2_alu_in(stage2_alu_in), .rs2_data_in(rs2_data_in),
    .stage2_valid(stage2_valid), .stage3_inst(stage3_inst),
    .wb_data(wb_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .stall_out(stall_out), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .dmem_err(dmem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic abortRun(input string what);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait bound expired before the DUT made progress", what);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic bit isMem(input item_t it);
    return it.valid && (it.inst[6:0] == LOAD || it.inst[6:0] == STORE);
  endfunction

  // Reference model: what retiring this instruction must look like.
  function automatic exp_t model(input item_t it);
    exp_t        e;
    logic [31:0] inst, raw, v;
    logic [6:0]  opc;
    logic [2:0]  f3;
    int          nbytes, lane;
    inst   = it.valid ? it.inst : NOP_INST;
    opc    = inst[6:0];
    f3     = inst[14:12];
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lane   = (nbytes == 1) ? int'(it.alu[1:0]) : (nbytes == 2) ? (int'(it.alu[1:0]) & 2) : 0;
    e.inst    = inst;
    e.waddr   = inst[11:7];
    e.mem     = 0;
    e.addr    = it.alu & 32'hFFFFFFFC;
    e.mask    = 4'd0;
    e.wdata   = 32'd0;
    e.stall   = 0;
    e.timeout = 0;
    e.wb      = it.alu;
    if (opc == 7'b1101111 || opc == 7'b1100111) begin
      e.wb = it.pc + 32'd4;
    end else if (opc == LOAD) begin
      e.mem = 1;
      if (it.noRsp) begin
        e.timeout = 1;
        e.wb      = 32'd0;
        e.stall   = it.readyDelay + 1 + 255;
      end else begin
        e.stall = it.readyDelay + 1 + it.rspDelay;
        raw = it.rdata >> (8 * lane);
        if (nbytes == 1) begin
          v = raw & 32'h000000FF;
          if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end else if (nbytes == 2) begin
          v = raw & 32'h0000FFFF;
          if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end else begin
          v = raw;
        end
        e.wb = v;
      end
    end else if (opc == STORE) begin
      e.mem   = 1;
      e.stall = it.readyDelay;
      e.mask  = 4'(((1 << nbytes) - 1) << lane);
      e.wdata = it.rs2 << (8 * lane);
    end
    e.we = (opc inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                        7'b1101111, 7'b1100111, LOAD}) && (inst[11:7] != 5'd0);
    return e;
  endfunction

  function automatic item_t mkItem(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] alu, input logic [31:0] rs2,
                                   input logic [31:0] rdata, input int readyDelay,
                                   input int rspDelay, input bit noRsp);
    item_t it;
    it.inst = inst; it.pc = pc; it.alu = alu; it.rs2 = rs2; it.rdata = rdata;
    it.valid = 1'b1; it.readyDelay = readyDelay; it.rspDelay = rspDelay; it.noRsp = noRsp;
    return it;
  endfunction

  function automatic item_t randItem();
    item_t      it;
    logic [2:0] f3;
    it = mkItem($urandom, $urandom & 32'hFFFFFFFC, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
    case ($urandom_range(0, 9))
      0: it.valid = 1'b0;
      1: it.inst[6:0] = 7'b0110011;
      2: it.inst[6:0] = 7'b0010011;
      3: it.inst[6:0] = ($urandom_range(0, 1) != 0) ? 7'b0110111 : 7'b0010111;
      4: it.inst[6:0] = ($urandom_range(0, 1) != 0) ? 7'b1101111 : 7'b1100111;
      5, 6: begin
        it.inst[6:0] = LOAD;
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        it.inst[14:12] = f3;
        if ($urandom_range(0, 59) == 0) it.noRsp = 1'b1;
      end
      7, 8: begin
        it.inst[6:0]   = STORE;
        it.inst[14:12] = 3'($urandom_range(0, 2));
      end
      default: it.inst[6:0] = ($urandom_range(0, 1) != 0) ? 7'b1100011 : 7'b1110011;
    endcase
    if ($urandom_range(0, 7) == 0) it.inst[11:7] = 5'd0;
    return it;
  endfunction

  // Called just after a rising edge; returns just after the edge that captured the item.
  task automatic applyStimulus(input item_t it);
    int guard;
    guard = 0;
    stage2_inst_in = it.inst;
    stage2_pc_in   = it.pc;
    stage2_alu_in  = it.alu;
    rs2_data_in    = it.rs2;
    stage2_valid   = it.valid;
    if (isMem(it)) mq.push_back(it);
    @(negedge clk);
    while (stall_out) begin
      guard++;
      if (guard > 1000) abortRun("capture_wait");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    sbq.push_back(model(it));
  endtask

  // Memory responder: ready after readyDelay cycles, load data after rspDelay wait cycles.
  initial begin : memProc
    int    waitCnt;
    int    rspCnt;
    bit    phase;
    item_t cur;
    waitCnt = 0;
    rspCnt  = 0;
    phase   = 0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!memAuto) continue;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = $urandom;
      if (phase) begin
        cur = mq[0];
        if (!cur.noRsp && rspCnt == cur.rspDelay) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata     = cur.rdata;
          phase          = 0;
          void'(mq.pop_front());
        end else if (cur.noRsp && rspCnt == 255) begin
          phase = 0;
          void'(mq.pop_front());
        end else begin
          rspCnt++;
        end
      end else if (dmem_req_valid && mq.size() > 0) begin
        cur = mq[0];
        if (waitCnt == cur.readyDelay) begin
          dmem_req_ready = 1'b1;
          waitCnt        = 0;
          if (cur.inst[6:0] == LOAD) begin
            phase  = 1;
            rspCnt = 0;
          end else begin
            void'(mq.pop_front());
          end
        end else begin
          waitCnt++;
        end
      end
    end
  end

  initial begin : monitorProc
    exp_t e;
    int   stallCnt;
    bit   errModel;
    stallCnt = 0;
    errModel = 0;
    forever begin
      @(negedge clk);
      if (!monOn) continue;
      if (dmem_req_valid) begin
        if (sbq.size() == 0 || !sbq[0].mem) begin
          checkOutput("req_valid_unexpected", 32'(dmem_req_valid), 32'd0);
        end else begin
          checkOutput("dmem_addr", dmem_addr, sbq[0].addr);
          checkOutput("dmem_we", 32'(dmem_we), 32'(sbq[0].mask));
          checkOutput("dmem_wdata", dmem_wdata, sbq[0].wdata);
        end
      end
      if (stall_out) begin
        stallCnt++;
        checkOutput("rf_we_during_stall", 32'(rf_we), 32'd0);
      end else if (sbq.size() == 0) begin
        if (!draining) checkOutput("retire_without_expectation", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        checkOutput("stage3_inst", stage3_inst, e.inst);
        checkOutput("rf_we", 32'(rf_we), 32'(e.we));
        checkOutput("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
        checkOutput("wb_data", wb_data, e.wb);
        checkOutput("stall_cycles", 32'(stallCnt), 32'(e.stall));
        checkOutput("dmem_err", 32'(dmem_err), 32'(errModel));
        if (e.timeout) errModel = 1;
        stallCnt = 0;
      end
    end
  end

  initial begin : stimulusProc
    item_t zero;
    int    guard;
    rst_n          = 1'b0;
    stage2_inst_in = 32'd0;
    stage2_pc_in   = 32'd0;
    stage2_alu_in  = 32'd0;
    rs2_data_in    = 32'd0;
    stage2_valid   = 1'b0;
    zero = mkItem(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 1'b0);
    zero.valid = 1'b0;
    #12;
    checkOutput("reset_stall_out", 32'(stall_out), 32'd0);
    checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
    checkOutput("reset_req_valid", 32'(dmem_req_valid), 32'd0);
    checkOutput("reset_stage3_inst", stage3_inst, NOP_INST);
    checkOutput("reset_dmem_err", 32'(dmem_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.push_back(model(zero));
    monOn = 1;

    applyStimulus(mkItem({7'd0, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011}, 32'h40, 32'h00001234, 32'd0, 32'd0, 0, 0, 1'b0));
    applyStimulus(mkItem({12'd0, 5'd1, 3'b000, 5'd6, 7'b0000011}, 32'h44, 32'h00001003, 32'd0, 32'h80FF0000, 0, 2, 1'b0));
    applyStimulus(mkItem({12'd0, 5'd1, 3'b100, 5'd7, 7'b0000011}, 32'h48, 32'h00001003, 32'd0, 32'h80FF0000, 0, 2, 1'b0));
    applyStimulus(mkItem({7'd0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b0100011}, 32'h4C, 32'h00002002, 32'h0000ABCD, 32'd0, 3, 0, 1'b0));
    applyStimulus(mkItem({20'd0, 5'd1, 7'b1101111}, 32'h00000100, 32'h00000200, 32'd0, 32'd0, 0, 0, 1'b0));
    applyStimulus(mkItem({20'd0, 5'd0, 7'b1101111}, 32'h00000100, 32'h00000200, 32'd0, 32'd0, 0, 0, 1'b0));
    applyStimulus(mkItem({12'd0, 5'd1, 3'b010, 5'd8, 7'b0000011}, 32'h50, 32'h00000010, 32'd0, 32'd0, 0, 0, 1'b1));
    applyStimulus(mkItem({7'd0, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011}, 32'h54, 32'hCAFEF00D, 32'd0, 32'd0, 0, 0, 1'b0));

    for (int i = 0; i < 150; i++) begin
      applyStimulus(randItem());
    end

    applyStimulus(zero);
    draining = 1;
    guard = 0;
    while (sbq.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 600) abortRun("drain_wait");
    end
    @(posedge clk);
    #1;
    monOn   = 0;
    memAuto = 0;
    dmem_req_ready = 1'b1;
    dmem_rsp_valid = 1'b0;

    // Asynchronous reset while a load waits for its response.
    stage2_inst_in = {12'd0, 5'd1, 3'b010, 5'd9, 7'b0000011};
    stage2_alu_in  = 32'h00003000;
    stage2_valid   = 1'b1;
    @(posedge clk);
    #1;
    stage2_valid = 1'b0;
    @(posedge clk);
    #1;
    dmem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wait_rsp_stall_out", 32'(stall_out), 32'd1);
    checkOutput("wait_rsp_req_valid", 32'(dmem_req_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_stall_out", 32'(stall_out), 32'd0);
    checkOutput("midreset_req_valid", 32'(dmem_req_valid), 32'd0);
    checkOutput("midreset_stage3_inst", stage3_inst, NOP_INST);
    checkOutput("midreset_rf_we", 32'(rf_we), 32'd0);
    checkOutput("midreset_dmem_err", 32'(dmem_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'h12345678;
    @(negedge clk);
    checkOutput("late_rsp_rf_we", 32'(rf_we), 32'd0);
    checkOutput("late_rsp_stall_out", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("late_rsp_stage3_inst", stage3_inst, NOP_INST);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
